// File: rtl/packet_buffer_lane_allocator.sv
// packet_buffer_lane_allocator
//   Steers incoming packet beats into one of NUM_LANES lane FIFOs. The lane is
//   chosen on the first beat (header) of a packet. Only lanes with room for the
//   whole packet qualify, and among those the least-filled lane wins. The rest
//   of the packet follows that lane. A packet longer than a whole FIFO is
//   accepted and discarded beat by beat. Per-lane occupancy is tracked here
//   from the write strobes and the downstream pops.
//
//   Optional feature: define PKT_BUF_ALLOC_RR_TIEBREAK_EN to resolve ties
//   between equally filled lanes round-robin. When it is not defined, a tie
//   goes to the lowest lane index.
//
//   Ports
//     clk_i, rst_ni    clock, async active-low reset
//     in_valid_i       upstream beat valid
//     in_len_i         packet length in bytes (header beat only)
//     in_ready_o       beat accepted when in_valid_i && in_ready_o
//     lane_sel_o       lane owning the current beat
//     lane_we_o        one-hot lane FIFO write strobe
//     drop_o           accepted beat is discarded (oversize packet)
//     lane_pop_i       per-lane FIFO read strobe
//     fill_level_o     packed per-lane occupancy, FILL_W bits per lane
//     err_underflow_o  sticky: a lane was popped while empty

// Occupancy counter for one lane.
module packet_buffer_lane_allocator_lane #(
  parameter int FILL_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_we,
  input  logic              i_pop,
  output logic [FILL_W-1:0] o_fill,
  output logic              o_underflow
);
  logic [FILL_W-1:0] r_fill;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_fill <= '0;
    else begin
      unique case ({i_we, i_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   if (r_fill != '0) r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign o_fill      = r_fill;
  assign o_underflow = i_pop & ~i_we & (r_fill == '0);
endmodule

module packet_buffer_lane_allocator #(
  parameter  int NUM_LANES  = 4,
  parameter  int AXI_WIDTH  = 64,
  parameter  int FIFO_DEPTH = 16,
  parameter  int LEN_WIDTH  = 16,
  localparam int LANE_IDX_W = $clog2(NUM_LANES),
  localparam int FILL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  input  logic [LEN_WIDTH-1:0]          in_len_i,
  output logic                          in_ready_o,
  output logic [LANE_IDX_W-1:0]         lane_sel_o,
  output logic [NUM_LANES-1:0]          lane_we_o,
  output logic                          drop_o,
  input  logic [NUM_LANES-1:0]          lane_pop_i,
  output logic [NUM_LANES*FILL_W-1:0]   fill_level_o,
  output logic                          err_underflow_o
);
  localparam int BEAT_BYTES = AXI_WIDTH / 8;
  localparam int CW         = LEN_WIDTH + 1;  // beat count width, no truncation
  localparam int SW         = CW + 1;         // fill + beats sum width

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DROP} state_t;

  state_t                             r_state, w_state_nxt;
  logic [CW-1:0]                      r_remaining, w_remaining_nxt;
  logic [LANE_IDX_W-1:0]              r_lane, w_lane_nxt, w_sel, w_best_idx;
  logic [CW-1:0]                      w_len_ext, w_beats;
  logic                               w_oversize, w_found, w_ready, w_drop_cond;
  logic                               w_acc, w_we;
  logic                               r_err;
  logic [FILL_W-1:0]                  w_best_fill;
  logic [NUM_LANES-1:0]               w_elig, w_lane_we, w_uf;
  logic [NUM_LANES-1:0][FILL_W-1:0]   w_fill;

  // Header decode: ceil(len / BEAT_BYTES), with a zero length still one beat.
  assign w_len_ext  = {1'b0, in_len_i};
  assign w_beats    = (in_len_i == '0) ? CW'(1)
                                       : (w_len_ext + CW'(BEAT_BYTES - 1)) / CW'(BEAT_BYTES);
  assign w_oversize = {1'b0, w_beats} > SW'(FIFO_DEPTH);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_elig[g] = ({1'b0, w_beats} + SW'(w_fill[g])) <= SW'(FIFO_DEPTH);

    packet_buffer_lane_allocator_lane #(.FILL_W(FILL_W)) u_lane (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_we        (w_lane_we[g]),
      .i_pop       (lane_pop_i[g]),
      .o_fill      (w_fill[g]),
      .o_underflow (w_uf[g])
    );
  end

`ifdef PKT_BUF_ALLOC_RR_TIEBREAK_EN
  logic [LANE_IDX_W-1:0] r_rr_ptr;

  // Advance past the lane that just took a packet so equal-fill lanes rotate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rr_ptr <= '0;
    else if (w_acc && r_state == S_IDLE && !w_drop_cond)
      r_rr_ptr <= (w_sel == LANE_IDX_W'(NUM_LANES - 1)) ? '0 : w_sel + 1'b1;
  end
`endif

  // Min-fill search. The scan starts at the tie-break origin and only a
  // strictly smaller fill replaces the current best, so the first lane
  // scanned wins any tie.
  always_comb begin
    int idx;
    idx         = 0;
    w_found     = 1'b0;
    w_best_idx  = '0;
    w_best_fill = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
`ifdef PKT_BUF_ALLOC_RR_TIEBREAK_EN
      idx = (int'(r_rr_ptr) + k) % NUM_LANES;
`else
      idx = k;
`endif
      if (w_elig[idx] && (!w_found || w_fill[idx] < w_best_fill)) begin
        w_found     = 1'b1;
        w_best_idx  = LANE_IDX_W'(idx);
        w_best_fill = w_fill[idx];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_lane_nxt      = r_lane;
    w_sel           = r_lane;
    w_ready         = 1'b0;
    w_drop_cond     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_sel       = w_best_idx;
        // Oversize packets are always accepted so they can be drained.
        w_ready     = w_found | w_oversize;
        w_drop_cond = w_oversize;
        if (in_valid_i && w_ready && w_beats != CW'(1)) begin
          w_remaining_nxt = w_beats - 1'b1;
          w_state_nxt     = w_oversize ? S_DROP : S_BURST;
          if (!w_oversize) w_lane_nxt = w_best_idx;
        end
      end
      S_BURST, S_DROP: begin
        w_ready     = 1'b1;
        w_drop_cond = (r_state == S_DROP);
        if (in_valid_i) begin
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == CW'(1)) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_lane      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_lane      <= w_lane_nxt;
      r_err       <= r_err | (|w_uf);
    end
  end

  // Handshake outputs are masked while reset is asserted so nothing is
  // written or dropped during an abandoned packet.
  assign w_acc     = in_valid_i & w_ready & rst_ni;
  assign w_we      = w_acc & ~w_drop_cond;
  assign w_lane_we = w_we ? (NUM_LANES'(1) << w_sel) : '0;

  assign in_ready_o      = w_ready & rst_ni;
  assign lane_sel_o      = w_sel;
  assign lane_we_o       = w_lane_we;
  assign drop_o          = w_acc & w_drop_cond;
  assign fill_level_o    = w_fill;
  assign err_underflow_o = r_err;
endmodule

// File: tb/tb_packet_buffer_lane_allocator.sv
// Self-checking bench for packet_buffer_lane_allocator (default parameters).
module tb_packet_buffer_lane_allocator;
  localparam int NL = 4;
  localparam int FW = 5;

  logic            clk_i, rst_ni, in_valid_i;
  logic [15:0]     in_len_i;
  logic            in_ready_o, drop_o, err_underflow_o;
  logic [1:0]      lane_sel_o;
  logic [NL-1:0]   lane_we_o, lane_pop_i;
  logic [NL*FW-1:0] fill_level_o;

  packet_buffer_lane_allocator dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_len_i(in_len_i),
    .in_ready_o(in_ready_o), .lane_sel_o(lane_sel_o), .lane_we_o(lane_we_o),
    .drop_o(drop_o), .lane_pop_i(lane_pop_i), .fill_level_o(fill_level_o),
    .err_underflow_o(err_underflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [15:0] len;
    logic [3:0]  pop;
    logic        rdy;
    logic [1:0]  sel;
    logic        csel;
    logic [3:0]  we;
    logic        drop;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[17];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   m_fill[NL];
  logic m_uf;

  function automatic vec_t mk(logic v, logic [15:0] len, logic [3:0] pop, logic rdy,
                              logic [1:0] sel, logic csel, logic [3:0] we, logic drop);
    vec_t e;
    e.v = v; e.len = len; e.pop = pop; e.rdy = rdy;
    e.sel = sel; e.csel = csel; e.we = we; e.drop = drop;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_state();
    for (int i = 0; i < NL; i++)
      chk($sformatf("fill%0d", i), 32'(fill_level_o[i*FW +: FW]), 32'(m_fill[i]));
    chk("err_underflow", 32'(err_underflow_o), 32'(m_uf));
  endtask

  // One clock of stimulus: expectation is queued as the inputs are driven,
  // then popped and compared against the combinational outputs mid-cycle.
  task automatic cyc(input vec_t e);
    vec_t x;
    exp_q.push_back(e);
    in_valid_i = e.v; in_len_i = e.len; lane_pop_i = e.pop;
    #3;
    x = exp_q.pop_front();
    chk("ready", 32'(in_ready_o), 32'(x.rdy));
    chk("we",    32'(lane_we_o),  32'(x.we));
    chk("drop",  32'(drop_o),     32'(x.drop));
    if (x.csel) chk("sel", 32'(lane_sel_o), 32'(x.sel));
    @(posedge clk_i); #1;
    for (int i = 0; i < NL; i++) begin
      if (x.we[i] && !x.pop[i]) m_fill[i]++;
      else if (!x.we[i] && x.pop[i]) begin
        if (m_fill[i] == 0) m_uf = 1'b1;
        else m_fill[i]--;
      end
    end
    in_valid_i = 1'b0; lane_pop_i = '0;
  endtask

  task automatic send_pkt(input int len, input int lane);
    int   b;
    logic dr;
    b  = (len == 0) ? 1 : (len + 7) / 8;
    dr = (b > 16);
    for (int j = 0; j < b; j++)
      cyc(mk(1'b1, 16'(len), 4'b0, 1'b1, 2'(lane), !dr, dr ? 4'b0 : 4'(1) << lane, dr));
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0; lane_pop_i = '0; in_len_i = '0;
    rst_ni = 1'b0;
    for (int i = 0; i < NL; i++) m_fill[i] = 0;
    m_uf = 1'b0;
    #2;
    chk_state();
    chk("rst_we",   32'(lane_we_o),  32'(0));
    chk("rst_drop", 32'(drop_o),     32'(0));
    chk("rst_sel",  32'(lane_sel_o), 32'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    // Cycle script: lane choice, burst hold, stall, pop, underflow, write+pop.
    tbl[0]  = mk(1, 20,  4'b0000, 1, 0, 1, 4'b0001, 0); // 3-beat header -> lane 0
    tbl[1]  = mk(1, 999, 4'b0000, 1, 0, 1, 4'b0001, 0); // len ignored in BURST
    tbl[2]  = mk(0, 0,   4'b0000, 1, 0, 1, 4'b0000, 0); // stall holds BURST
    tbl[3]  = mk(1, 0,   4'b0000, 1, 0, 1, 4'b0001, 0); // last beat
    tbl[4]  = mk(1, 8,   4'b0000, 1, 1, 1, 4'b0010, 0); // 1 beat -> lane 1
    tbl[5]  = mk(1, 16,  4'b0000, 1, 2, 1, 4'b0100, 0); // 2 beats -> lane 2
    tbl[6]  = mk(1, 16,  4'b0000, 1, 2, 1, 4'b0100, 0);
    tbl[7]  = mk(1, 0,   4'b0000, 1, 3, 1, 4'b1000, 0); // len 0 = 1 beat -> lane 3
    tbl[8]  = mk(1, 1,   4'b0001, 1, 1, 1, 4'b0010, 0); // {3,1,2,1} -> lane 1, pop 0
    tbl[9]  = mk(0, 0,   4'b1000, 1, 3, 1, 4'b0000, 0); // pop lane 3 -> 0
    tbl[10] = mk(0, 0,   4'b1000, 1, 3, 1, 4'b0000, 0); // pop empty -> underflow
    tbl[11] = mk(1, 48,  4'b0000, 1, 3, 1, 4'b1000, 0); // 6 beats -> lane 3
    tbl[12] = mk(1, 48,  4'b1000, 1, 3, 1, 4'b1000, 0); // write+pop same lane
    tbl[13] = mk(1, 48,  4'b0000, 1, 3, 1, 4'b1000, 0);
    tbl[14] = mk(1, 48,  4'b0000, 1, 3, 1, 4'b1000, 0);
    tbl[15] = mk(1, 48,  4'b0000, 1, 3, 1, 4'b1000, 0);
    tbl[16] = mk(1, 48,  4'b0000, 1, 3, 1, 4'b1000, 0);

    do_reset();
    for (int r = 0; r < 17; r++) begin
      cyc(tbl[r]);
      chk_state();
    end

    // Oversize packets: 17 beats (just over depth) and 25 beats, all dropped.
    send_pkt(136, 0);
    send_pkt(200, 0);
    chk_state();
    send_pkt(8, 0);                 // next header handled normally
    chk_state();

    // Fill to {16,14,15,16}; a 3-beat header fits nowhere until lane 1 pops.
    do_reset();
    send_pkt(128, 0);
    send_pkt(112, 1);
    send_pkt(120, 2);
    send_pkt(128, 3);
    chk_state();
    cyc(mk(0, 24, 4'b0000, 0, 0, 0, 4'b0000, 0));
    cyc(mk(0, 24, 4'b0010, 0, 0, 0, 4'b0000, 0));
    chk_state();
    cyc(mk(0, 24, 4'b0000, 1, 1, 1, 4'b0000, 0));
    send_pkt(24, 1);
    chk_state();

    // Reset mid-burst with 4 beats remaining.
    do_reset();
    cyc(mk(1, 48, 4'b0000, 1, 0, 1, 4'b0001, 0));
    cyc(mk(1, 48, 4'b0000, 1, 0, 1, 4'b0001, 0));
    in_valid_i = 1'b1; in_len_i = 16'd48;
    #1 rst_ni = 1'b0;
    for (int i = 0; i < NL; i++) m_fill[i] = 0;
    #1;
    chk_state();
    chk("mid_rst_we",   32'(lane_we_o),  32'(0));
    chk("mid_rst_drop", 32'(drop_o),     32'(0));
    chk("mid_rst_sel",  32'(lane_sel_o), 32'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc(mk(1, 8, 4'b0000, 1, 0, 1, 4'b0001, 0));  // header again, 1 beat
    cyc(mk(1, 8, 4'b0000, 1, 1, 1, 4'b0010, 0));  // IDLE still: new lane
    chk_state();

    // Four 1-beat packets, each popped in the same cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef PKT_BUF_ALLOC_RR_TIEBREAK_EN
      int ln = k;
`else
      int ln = 0;
`endif
      cyc(mk(1, 8, 4'(1) << ln, 1, 2'(ln), 1, 4'(1) << ln, 0));
    end
    chk_state();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/packet_buffer_lane_allocator.md
PACKET_BUFFER_LANE_ALLOCATOR -- requirements
Module: packet_buffer_lane_allocator

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of lane FIFOs (>=2).
REQ-002 SHALL have parameter AXI_WIDTH, default 64, data beat width in bits (multiple of 8); BEAT_BYTES = AXI_WIDTH/8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, per-lane capacity in beats.
REQ-004 SHALL have parameter LEN_WIDTH, default 16, width of header packet length in bytes.
REQ-005 SHALL have derived localparams LANE_IDX_W = $clog2(NUM_LANES) and FILL_W = $clog2(FIFO_DEPTH+1).
REQ-006 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port in_valid_i, input, 1, beat offered upstream.
REQ-009 SHALL have port in_len_i, input, LEN_WIDTH, packet length in bytes, sampled only on the first beat of a packet.
REQ-010 SHALL have port in_ready_o, output, 1, beat accepted when in_valid_i && in_ready_o.
REQ-011 SHALL have port lane_sel_o, output, LANE_IDX_W, lane owning the current beat.
REQ-012 SHALL have port lane_we_o, output, NUM_LANES, one-hot write strobe to lane FIFOs.
REQ-013 SHALL have port drop_o, output, 1, current accepted beat is discarded (oversize packet).
REQ-014 SHALL have port lane_pop_i, input, NUM_LANES, per-lane beat read from FIFO.
REQ-015 SHALL have port fill_level_o, output, NUM_LANES*FILL_W, packed per-lane occupancy in beats.
REQ-016 SHALL have port err_underflow_o, output, 1, sticky: pop seen on empty lane.

Function
REQ-017 SHALL compute beats = ceil(in_len_i / BEAT_BYTES); in_len_i = 0 counts as 1 beat; arithmetic at LEN_WIDTH+1 bits, no truncation.
REQ-018 SHALL implement FSM IDLE, BURST, DROP; IDLE expects first beat of a packet.
REQ-019 In IDLE, a lane SHALL be eligible iff fill + beats <= FIFO_DEPTH; the selected lane is the eligible lane with minimum fill, ties to lowest index (see REQ-030).
REQ-020 In IDLE, in_ready_o SHALL be 1 iff an eligible lane exists or beats > FIFO_DEPTH; combinational from in_len_i, zero added latency.
REQ-021 On IDLE accept with beats = 1 SHALL stay IDLE; beats > 1 SHALL latch lane, load remaining = beats-1, go BURST.
REQ-022 In BURST, in_ready_o SHALL be 1; lane_sel_o held at latched lane; remaining decrements per accepted beat; last beat (remaining = 1) returns to IDLE.
REQ-023 If beats > FIFO_DEPTH in IDLE, beat SHALL be accepted with drop_o = 1, lane_we_o = 0; remaining beats consumed in DROP with drop_o = 1, then IDLE; no fill change.
REQ-024 lane_we_o[lane] SHALL equal in_valid_i && in_ready_o && !drop_o, same cycle as the beat.
REQ-025 Per lane, fill SHALL update +1 on write, -1 on pop, unchanged on simultaneous write and pop.
REQ-026 Pop on lane with fill = 0 and no same-cycle write SHALL leave fill 0 and set err_underflow_o until reset.
REQ-027 Fill SHALL never exceed FIFO_DEPTH; guaranteed by REQ-019 as only the owning packet writes a lane.
REQ-028 Header fields SHALL be ignored outside IDLE; in_valid_i low in BURST/DROP holds state.

Reset
REQ-029 On rst_ni low, asynchronously: FSM IDLE, all fills 0, remaining 0, latched lane 0, lane_sel_o 0, lane_we_o 0, drop_o 0, err_underflow_o 0, round-robin pointer 0; a packet in flight is abandoned.

Configuration
REQ-030 Macro PKT_BUF_ALLOC_RR_TIEBREAK_EN: when defined, ties among equal-minimum eligible lanes SHALL resolve round-robin from a pointer advanced to selected lane+1 on each IDLE accept to a lane; when undefined, ties resolve to lowest index and no pointer exists.

Verification
REQ-031 Defaults, all fills 0, in_len_i = 20 -> 3 beats on lane 0, lane_we_o = 4'b0001 x3, fill_level lane0 = 3, FSM back to IDLE.
REQ-032 Fills {16,14,15,16}, in_len_i = 24 (3 beats) -> in_ready_o = 0; pop lane 1 -> fill 13, ready = 1, lane_sel_o = 1.
REQ-033 in_len_i = 200 (25 beats > 16) -> 25 beats accepted, drop_o = 1 each, lane_we_o = 0, fills unchanged.
REQ-034 Lane 2 fill 5, same-cycle write and pop -> fill 5; pop lane 3 at fill 0 -> err_underflow_o = 1, stays 1.
REQ-035 With PKT_BUF_ALLOC_RR_TIEBREAK_EN, all fills 0, four 1-beat packets each popped same cycle -> lanes 0,1,2,3; without macro -> lanes 0,0,0,0.
REQ-036 rst_ni low mid-BURST (remaining 4) -> outputs and fills 0 asynchronously; next beat treated as header in IDLE.
